// File: rtl/decode_stage.sv
// Decode stage of the non-forwarding pipeline: IF/ID register, 32x32 register file,
// immediate generator, RAW hazard detector and the registered ID/EX bundle.
module decode_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic        i_flush,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_regwen,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_regwen,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_regwen,
  input  logic [31:0] i_wb_data,
  output logic        o_stall,
  output logic [31:0] o_ex_pc,
  output logic [31:0] o_ex_inst,
  output logic [31:0] o_ex_rs1_data,
  output logic [31:0] o_ex_rs2_data,
  output logic [31:0] o_ex_imm,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_regwen
);

  localparam logic [6:0] OpLoad   = 7'b000_0011;
  localparam logic [6:0] OpImm    = 7'b001_0011;
  localparam logic [6:0] OpAuipc  = 7'b001_0111;
  localparam logic [6:0] OpStore  = 7'b010_0011;
  localparam logic [6:0] OpReg    = 7'b011_0011;
  localparam logic [6:0] OpLui    = 7'b011_0111;
  localparam logic [6:0] OpBranch = 7'b110_0011;
  localparam logic [6:0] OpJalr   = 7'b110_0111;
  localparam logic [6:0] OpJal    = 7'b110_1111;

  logic [31:0] ifid_pc_q, ifid_inst_q;
  logic [31:0] rf_q [32];

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, regwen;
  logic [31:0] imm;
  logic [31:0] rs1_data, rs2_data;
  logic        hit_ex, hit_mem, stall_raw;

  assign opcode = ifid_inst_q[6:0];
  assign rd     = ifid_inst_q[11:7];
  assign rs1    = ifid_inst_q[19:15];
  assign rs2    = ifid_inst_q[24:20];

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    regwen   = 1'b0;
    imm      = '0;
    case (opcode)
      OpImm, OpLoad, OpJalr: begin
        rs1_used = 1'b1;
        regwen   = 1'b1;
        imm      = {{20{ifid_inst_q[31]}}, ifid_inst_q[31:20]};
      end
      OpStore: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = {{20{ifid_inst_q[31]}}, ifid_inst_q[31:25], ifid_inst_q[11:7]};
      end
      OpBranch: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = {{19{ifid_inst_q[31]}}, ifid_inst_q[31], ifid_inst_q[7],
                    ifid_inst_q[30:25], ifid_inst_q[11:8], 1'b0};
      end
      OpReg: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        regwen   = 1'b1;
      end
      OpLui, OpAuipc: begin
        regwen = 1'b1;
        imm    = {ifid_inst_q[31:12], 12'h000};
      end
      OpJal: begin
        regwen = 1'b1;
        imm    = {{11{ifid_inst_q[31]}}, ifid_inst_q[31], ifid_inst_q[19:12],
                  ifid_inst_q[20], ifid_inst_q[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Write-through bypass means an instruction in WB never needs a stall.
  assign rs1_data = (rs1 == 5'd0) ? 32'h0 :
                    (i_wb_regwen && i_wb_rd == rs1) ? i_wb_data : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'h0 :
                    (i_wb_regwen && i_wb_rd == rs2) ? i_wb_data : rf_q[rs2];

  assign hit_ex  = i_ex_regwen && (i_ex_rd != 5'd0) &&
                   ((rs1_used && rs1 == i_ex_rd) || (rs2_used && rs2 == i_ex_rd));
  assign hit_mem = i_mem_regwen && (i_mem_rd != 5'd0) &&
                   ((rs1_used && rs1 == i_mem_rd) || (rs2_used && rs2 == i_mem_rd));
  assign stall_raw = hit_ex | hit_mem;
  assign o_stall   = stall_raw & ~i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (i_wb_regwen && i_wb_rd != 5'd0) begin
      rf_q[i_wb_rd] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ifid_pc_q   <= RESET_PC;
      ifid_inst_q <= NOP_INST;
    end else if (i_flush) begin
      ifid_pc_q   <= i_pc;
      ifid_inst_q <= NOP_INST;
    end else if (!o_stall) begin
      ifid_pc_q   <= i_pc;
      ifid_inst_q <= i_inst;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || 1'b0) begin
      o_ex_pc       <= '0;
      o_ex_inst     <= NOP_INST;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
      o_ex_rd       <= '0;
      o_ex_regwen   <= 1'b0;
    end else if (i_flush || stall_raw) begin
      o_ex_pc       <= '0;
      o_ex_inst     <= NOP_INST;
      o_ex_rs1_data <= '0;
      o_ex_rs2_data <= '0;
      o_ex_imm      <= '0;
      o_ex_rd       <= '0;
      o_ex_regwen   <= 1'b0;
    end else begin
      o_ex_pc       <= ifid_pc_q;
      o_ex_inst     <= ifid_inst_q;
      o_ex_rs1_data <= rs1_data;
      o_ex_rs2_data <= rs2_data;
      o_ex_imm      <= imm;
      // Stores and branches carry rd = 0 so downstream never sees a phantom destination.
      o_ex_rd       <= regwen ? rd : 5'd0;
      o_ex_regwen   <= regwen;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for decode/immediate/hazard logic, plus
// hand-written sequences with a small EX/MEM/WB model closing the hazard loop.
module tb_decode_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, inst;
  logic        flush;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_rw, mem_rw, wb_rw;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] ex_pc, ex_inst, ex_rs1, ex_rs2, ex_imm;
  logic [4:0]  ex_rd_o;
  logic        ex_rw_o;

  // Directly driven downstream info, or the pipeline model when fb is set.
  logic        fb;
  logic [4:0]  d_ex_rd, d_mem_rd, d_wb_rd;
  logic        d_ex_rw, d_mem_rw, d_wb_rw;
  logic [31:0] d_wb_data;
  logic [4:0]  m_mem_rd, m_wb_rd;
  logic        m_mem_rw, m_wb_rw;
  logic [31:0] m_mem_data, m_wb_data, alu_res;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc         (pc),
    .i_inst       (inst),
    .i_flush      (flush),
    .i_ex_rd      (ex_rd),
    .i_ex_regwen  (ex_rw),
    .i_mem_rd     (mem_rd),
    .i_mem_regwen (mem_rw),
    .i_wb_rd      (wb_rd),
    .i_wb_regwen  (wb_rw),
    .i_wb_data    (wb_data),
    .o_stall      (stall),
    .o_ex_pc      (ex_pc),
    .o_ex_inst    (ex_inst),
    .o_ex_rs1_data(ex_rs1),
    .o_ex_rs2_data(ex_rs2),
    .o_ex_imm     (ex_imm),
    .o_ex_rd      (ex_rd_o),
    .o_ex_regwen  (ex_rw_o)
  );

  assign ex_rd   = fb ? ex_rd_o    : d_ex_rd;
  assign ex_rw   = fb ? ex_rw_o    : d_ex_rw;
  assign mem_rd  = fb ? m_mem_rd   : d_mem_rd;
  assign mem_rw  = fb ? m_mem_rw   : d_mem_rw;
  assign wb_rd   = fb ? m_wb_rd    : d_wb_rd;
  assign wb_rw   = fb ? m_wb_rw    : d_wb_rw;
  assign wb_data = fb ? m_wb_data  : d_wb_data;

  assign alu_res = (ex_inst[6:0] == 7'h13) ? ex_rs1 + ex_imm :
                   (ex_inst[6:0] == 7'h33) ? ex_rs1 + ex_rs2 : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mem_rd <= '0; m_mem_rw <= 1'b0; m_mem_data <= '0;
      m_wb_rd  <= '0; m_wb_rw  <= 1'b0; m_wb_data  <= '0;
    end else begin
      m_mem_rd <= ex_rd_o;  m_mem_rw <= ex_rw_o;  m_mem_data <= alu_res;
      m_wb_rd  <= m_mem_rd; m_wb_rw  <= m_mem_rw; m_wb_data  <= m_mem_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    fb = 1'b0; flush = 1'b0;
    d_ex_rd = '0; d_ex_rw = 1'b0; d_mem_rd = '0; d_mem_rw = 1'b0;
    d_wb_rd = '0; d_wb_rw = 1'b0; d_wb_data = '0;
  endtask

  task automatic do_reset();
    quiet();
    pc = '0; inst = Nop;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Puts addi x1,x0,7 then add x2,x1,x1 into the pipe; returns just after the add
  // reaches IF/ID with the addi in EX.
  task automatic load_raw_pair();
    fb = 1'b1;
    pc = 32'h200; inst = 32'h0070_0093;
    step();
    pc = 32'h204; inst = 32'h0010_8133;
    step();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  ex_rd;
    logic        ex_rw;
    logic [4:0]  mem_rd;
    logic        mem_rw;
    logic        stall;
    logic [31:0] imm;
    logic        regwen;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{32'h0070_0093,  5'd1, 1'b1,  5'd1, 1'b1, 1'b0, 32'h0000_0007, 1'b1, 5'd1};
    vecs[1]  = '{32'h0002_8333,  5'd5, 1'b1,  5'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 5'd6};
    vecs[2]  = '{32'h0002_8333,  5'd5, 1'b0,  5'd5, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 5'd6};
    vecs[3]  = '{32'h0002_8333,  5'd0, 1'b1,  5'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 5'd6};
    vecs[4]  = '{32'h0002_8333,  5'd5, 1'b0,  5'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 5'd6};
    vecs[5]  = '{32'hFE71_2E23,  5'd0, 1'b0,  5'd7, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0};
    vecs[6]  = '{32'hFE0F_8FE3, 5'd31, 1'b1,  5'd0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 5'd0};
    vecs[7]  = '{32'h8000_006F,  5'd0, 1'b0,  5'd0, 1'b0, 1'b0, 32'hFFF0_0000, 1'b1, 5'd0};
    vecs[8]  = '{32'h1234_5037,  5'd8, 1'b1,  5'd8, 1'b1, 1'b0, 32'h1234_5000, 1'b1, 5'd0};
    vecs[9]  = '{32'h0082_2183,  5'd8, 1'b1,  5'd0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 5'd3};
    vecs[10] = '{32'hFF04_80E7,  5'd0, 1'b0,  5'd9, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b1, 5'd1};
    vecs[11] = '{32'hFFFF_F517, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 32'hFFFF_F000, 1'b1, 5'd10};
    vecs[12] = '{32'h0010_0013,  5'd0, 1'b1,  5'd0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 5'd0};

    // Reset state.
    do_reset();
    check("reset ex_inst", ex_inst, Nop);
    check("reset ex_regwen", {31'b0, ex_rw_o}, 32'h0);
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset ex_pc", ex_pc, 32'h0);
    check("reset ex_rd", {27'b0, ex_rd_o}, 32'h0);
    check("reset ex_imm", ex_imm, 32'h0);

    // Decode, immediate and hazard table.
    for (int i = 0; i < 13; i++) begin
      quiet();
      pc = 32'h1000 + 32'(i * 4); inst = vecs[i].inst;
      step();
      inst = Nop;
      d_ex_rd = vecs[i].ex_rd; d_ex_rw = vecs[i].ex_rw;
      d_mem_rd = vecs[i].mem_rd; d_mem_rw = vecs[i].mem_rw;
      #1;
      check($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].stall});
      d_ex_rw = 1'b0; d_mem_rw = 1'b0;
      step();
      check($sformatf("vec%0d imm", i), ex_imm, vecs[i].imm);
      check($sformatf("vec%0d regwen", i), {31'b0, ex_rw_o}, {31'b0, vecs[i].regwen});
      check($sformatf("vec%0d rd", i), {27'b0, ex_rd_o}, {27'b0, vecs[i].rd});
      check($sformatf("vec%0d inst", i), ex_inst, vecs[i].inst);
    end

    // Register file reads zero after reset, then write-through and stored value.
    do_reset();
    pc = 32'h100; inst = 32'h0052_83B3;
    step();
    pc = 32'h104; inst = 32'h0002_8333;
    step();
    check("clean rs1", ex_rs1, 32'h0);
    check("clean rs2", ex_rs2, 32'h0);
    check("clean pc", ex_pc, 32'h100);
    pc = 32'h108; inst = Nop;
    d_wb_rd = 5'd5; d_wb_rw = 1'b1; d_wb_data = 32'hDEAD_BEEF;
    #1;
    check("wt stall", {31'b0, stall}, 32'h0);
    step();
    d_wb_rw = 1'b0;
    check("wt rs1", ex_rs1, 32'hDEAD_BEEF);
    check("wt rd", {27'b0, ex_rd_o}, 32'd6);
    check("wt pc", ex_pc, 32'h104);
    pc = 32'h10C; inst = 32'h0052_83B3;
    step();
    inst = Nop;
    step();
    check("stored rs1", ex_rs1, 32'hDEAD_BEEF);
    check("stored rs2", ex_rs2, 32'hDEAD_BEEF);

    // Back-to-back RAW: two stall cycles, two bubbles, then operands from WB.
    do_reset();
    load_raw_pair();
    check("raw c2 stall", {31'b0, stall}, 32'h1);
    check("raw c2 ex_inst", ex_inst, 32'h0070_0093);
    step();
    check("raw c3 stall", {31'b0, stall}, 32'h1);
    check("raw c3 bubble", ex_inst, Nop);
    check("raw c3 regwen", {31'b0, ex_rw_o}, 32'h0);
    step();
    check("raw c4 stall", {31'b0, stall}, 32'h0);
    check("raw c4 bubble", ex_inst, Nop);
    pc = 32'h208; inst = Nop;
    step();
    check("raw issue inst", ex_inst, 32'h0010_8133);
    check("raw issue rs1", ex_rs1, 32'd7);
    check("raw issue rs2", ex_rs2, 32'd7);
    check("raw issue rd", {27'b0, ex_rd_o}, 32'd2);
    check("raw issue pc", ex_pc, 32'h204);

    // x0 is never a hazard and never written.
    do_reset();
    fb = 1'b1;
    pc = 32'h300; inst = 32'h0010_0013;
    step();
    pc = 32'h304; inst = 32'h0000_0133;
    step();
    check("x0 stall ex", {31'b0, stall}, 32'h0);
    fb = 1'b0;
    d_wb_rd = 5'd0; d_wb_rw = 1'b1; d_wb_data = 32'hFFFF_FFFF;
    pc = 32'h308; inst = 32'h0000_0133;
    #1;
    check("x0 stall wb", {31'b0, stall}, 32'h0);
    step();
    check("x0 wt rs1", ex_rs1, 32'h0);
    check("x0 issue", ex_inst, 32'h0000_0133);
    d_wb_rw = 1'b0;
    inst = Nop;
    step();
    check("x0 stored rs1", ex_rs1, 32'h0);
    check("x0 stored rs2", ex_rs2, 32'h0);

    // Flush during a stall.
    do_reset();
    load_raw_pair();
    check("fl pre stall", {31'b0, stall}, 32'h1);
    flush = 1'b1;
    #1;
    check("fl forced stall", {31'b0, stall}, 32'h0);
    step();
    flush = 1'b0;
    pc = 32'h400; inst = 32'h0050_0193;
    #1;
    check("fl ex bubble", ex_inst, Nop);
    check("fl ex regwen", {31'b0, ex_rw_o}, 32'h0);
    check("fl stall after", {31'b0, stall}, 32'h0);
    step();
    check("fl ifid nop", ex_inst, Nop);
    pc = 32'h404; inst = Nop;
    step();
    check("fl target pc", ex_pc, 32'h400);
    check("fl target inst", ex_inst, 32'h0050_0193);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    load_raw_pair();
    check("rs pre stall", {31'b0, stall}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rs stall", {31'b0, stall}, 32'h0);
    check("rs ex_inst", ex_inst, Nop);
    check("rs ex_regwen", {31'b0, ex_rw_o}, 32'h0);
    check("rs ex_rd", {27'b0, ex_rd_o}, 32'h0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
